// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory stage of the 5-stage MIPS pipeline.
//
// Holds the EX/MEM pipeline latch, performs loads and stores against an
// internal word-organised data memory, and registers the result into the
// MEM/WB latch. It also supplies the forwarding sources for the execute stage.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses. A trapped store is suppressed, and a trapped load loses its
// regwrite. Without the macro, misaligned accesses are aligned down and
// o_misalign stays 0.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), synchronous active-low reset
//   i_aluresult, i_regB   EX ALU result / effective address, EX store data
//   i_rd_rt               EX destination register
//   i_mem                 [0] memwrite [1] memread [3:2] size [4] unsigned
//   i_wb                  [0] regwrite [1] memtoreg
//   i_valid               EX instruction valid
//   i_halt                freeze both latches and suppress memory writes
//   i_flush               load a bubble into EX/MEM
//   i_dbg_addr/o_dbg_data combinational debug word read
//   o_exmem_*             EX/MEM latch outputs (forwarding)
//   o_wb_*                MEM/WB latch outputs (write-back / forwarding)
//   o_misalign            MEM/WB misaligned-access flag
//
// The byte-lane logic assumes a 32-bit word (four little-endian lanes).
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_BITS  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_aluresult,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic [4:0]            i_rd_rt,
  input  logic [4:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic                  i_valid,
  input  logic                  i_halt,
  input  logic                  i_flush,
  input  logic [ADDR_BITS-1:0]  i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_exmem_aluresult,
  output logic [4:0]            o_exmem_rd,
  output logic                  o_exmem_regwrite,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic [4:0]            o_wb_rd,
  output logic                  o_wb_regwrite,
  output logic                  o_wb_valid,
  output logic                  o_misalign,
  output logic [DATA_WIDTH-1:0] o_dbg_data
);

  // EX/MEM latch
  logic [DATA_WIDTH-1:0] exmem_alu_reg;
  logic [DATA_WIDTH-1:0] exmem_regb_reg;
  logic [4:0]            exmem_rd_reg;
  logic [4:0]            exmem_mem_reg;
  logic [1:0]            exmem_wb_reg;
  logic                  exmem_valid_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      exmem_alu_reg   <= '0;
      exmem_regb_reg  <= '0;
      exmem_rd_reg    <= '0;
      exmem_mem_reg   <= '0;
      exmem_wb_reg    <= '0;
      exmem_valid_reg <= 1'b0;
    end else if (!i_halt) begin
      if (i_flush) begin
        // Bubble: everything cleared so nothing stale can be forwarded.
        exmem_alu_reg   <= '0;
        exmem_regb_reg  <= '0;
        exmem_rd_reg    <= '0;
        exmem_mem_reg   <= '0;
        exmem_wb_reg    <= '0;
        exmem_valid_reg <= 1'b0;
      end else begin
        exmem_alu_reg   <= i_aluresult;
        exmem_regb_reg  <= i_regB;
        exmem_rd_reg    <= i_rd_rt;
        exmem_mem_reg   <= i_mem;
        exmem_wb_reg    <= i_wb;
        exmem_valid_reg <= i_valid;
      end
    end
  end

  // Access decode
  logic                 mem_write;
  logic                 mem_read;
  logic                 size_byte;
  logic                 size_half;
  logic                 size_word;
  logic                 is_unsigned;
  logic [1:0]           addr_lo;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 misalign;
  logic                 store_en;

  assign mem_write   = exmem_mem_reg[0];
  assign mem_read    = exmem_mem_reg[1];
  assign size_byte   = (exmem_mem_reg[3:2] == 2'b00);
  assign size_half   = (exmem_mem_reg[3:2] == 2'b01);
  assign size_word   = exmem_mem_reg[3];
  assign is_unsigned = exmem_mem_reg[4];
  assign addr_lo     = exmem_alu_reg[1:0];
  // Upper address bits are simply dropped, so accesses wrap modulo MEM_DEPTH.
  assign word_idx    = exmem_alu_reg[ADDR_BITS+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = exmem_valid_reg && (mem_write || mem_read) &&
                    ((size_half && addr_lo[0]) || (size_word && (addr_lo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign store_en = exmem_valid_reg && mem_write && !i_halt && !misalign;

  // Byte enables and lane-replicated store data. Half accesses ignore addr[0]
  // and word accesses ignore addr[1:0], which aligns them down.
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] store_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = gi;
      assign byte_en[gi] = size_word ||
                           (size_half && (LANE[1] == addr_lo[1])) ||
                           (size_byte && (LANE == addr_lo));
    end
  endgenerate

  assign store_data = size_word ? exmem_regb_reg :
                      size_half ? {2{exmem_regb_reg[15:0]}} :
                                  {4{exmem_regb_reg[7:0]}};

  // Data memory: no reset on contents; a store held in EX/MEM during reset
  // is dropped.
  logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset && store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_array[word_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  // Load path: the pre-write word is read, so a combined read/write returns
  // the old contents.
  logic [DATA_WIDTH-1:0] load_word;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_value;
  logic [DATA_WIDTH-1:0] wb_data_next;

  assign load_word = mem_array[word_idx];
  assign load_byte = load_word[{addr_lo, 3'b000} +: 8];
  assign load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_value = '0;
    if (mem_read) begin
      if (size_byte) begin
        load_value = {{(DATA_WIDTH-8){load_byte[7] & ~is_unsigned}}, load_byte};
      end else if (size_half) begin
        load_value = {{(DATA_WIDTH-16){load_half[15] & ~is_unsigned}}, load_half};
      end else begin
        load_value = load_word;
      end
    end
  end

  assign wb_data_next = exmem_wb_reg[1] ? load_value : exmem_alu_reg;

  // MEM/WB latch
  logic [DATA_WIDTH-1:0] wb_data_reg;
  logic [4:0]            wb_rd_reg;
  logic                  wb_regwrite_reg;
  logic                  wb_valid_reg;
  logic                  misalign_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wb_data_reg     <= '0;
      wb_rd_reg       <= '0;
      wb_regwrite_reg <= 1'b0;
      wb_valid_reg    <= 1'b0;
      misalign_reg    <= 1'b0;
    end else if (!i_halt) begin
      wb_data_reg     <= wb_data_next;
      wb_rd_reg       <= exmem_rd_reg;
      wb_regwrite_reg <= exmem_wb_reg[0] && exmem_valid_reg && !misalign;
      wb_valid_reg    <= exmem_valid_reg;
      misalign_reg    <= misalign;
    end
  end

  assign o_exmem_aluresult = exmem_alu_reg;
  assign o_exmem_rd        = exmem_rd_reg;
  assign o_exmem_regwrite  = exmem_wb_reg[0] && exmem_valid_reg;
  assign o_wb_data         = wb_data_reg;
  assign o_wb_rd           = wb_rd_reg;
  assign o_wb_regwrite     = wb_regwrite_reg;
  assign o_wb_valid        = wb_valid_reg;
  assign o_misalign        = misalign_reg;
  assign o_dbg_data        = mem_array[i_dbg_addr];

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage (default build,
// misalign trap disabled). Inputs change 1 time unit after a rising edge and
// outputs are sampled there too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [4:0] M_NONE = 5'b00000;
  localparam logic [4:0] M_SW   = 5'b01001;
  localparam logic [4:0] M_LW   = 5'b01010;
  localparam logic [4:0] M_LB   = 5'b00010;
  localparam logic [4:0] M_LBU  = 5'b10010;
  localparam logic [4:0] M_LH   = 5'b00110;
  localparam logic [4:0] M_LHU  = 5'b10110;
  localparam logic [4:0] M_SB   = 5'b00001;
  localparam logic [1:0] W_LOAD = 2'b11;
  localparam logic [1:0] W_ALU  = 2'b01;
  localparam logic [1:0] W_NONE = 2'b00;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_aluresult = '0;
  logic [31:0] i_regB = '0;
  logic [4:0]  i_rd_rt = '0;
  logic [4:0]  i_mem = '0;
  logic [1:0]  i_wb = '0;
  logic        i_valid = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_flush = 1'b0;
  logic [5:0]  i_dbg_addr = '0;
  logic [31:0] o_exmem_aluresult;
  logic [4:0]  o_exmem_rd;
  logic        o_exmem_regwrite;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_regwrite;
  logic        o_wb_valid;
  logic        o_misalign;
  logic [31:0] o_dbg_data;

  int checks = 0;
  int failures = 0;

  mem_stage #(.DATA_WIDTH(32), .MEM_DEPTH(64), .ADDR_BITS(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_aluresult(i_aluresult), .i_regB(i_regB), .i_rd_rt(i_rd_rt),
    .i_mem(i_mem), .i_wb(i_wb), .i_valid(i_valid),
    .i_halt(i_halt), .i_flush(i_flush), .i_dbg_addr(i_dbg_addr),
    .o_exmem_aluresult(o_exmem_aluresult), .o_exmem_rd(o_exmem_rd),
    .o_exmem_regwrite(o_exmem_regwrite), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_wb_regwrite(o_wb_regwrite), .o_wb_valid(o_wb_valid),
    .o_misalign(o_misalign), .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one EX-stage instruction and clock it into EX/MEM.
  task automatic issue(input logic [31:0] alu, input logic [31:0] regb,
                       input logic [4:0] rd, input logic [4:0] mem,
                       input logic [1:0] wb, input logic valid);
    i_aluresult = alu;
    i_regB      = regb;
    i_rd_rt     = rd;
    i_mem       = mem;
    i_wb        = wb;
    i_valid     = valid;
    $display("txn t=%0t rst_n=%0b halt=%0b flush=%0b alu=0x%08h regB=0x%08h rd=%0d mem=%05b wb=%02b v=%0b",
             $time, i_reset, i_halt, i_flush, alu, regb, rd, mem, wb, valid);
    step();
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 5'd0, M_NONE, W_NONE, 1'b0);
  endtask

  task automatic check_dbg(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    i_dbg_addr = addr;
    #1;
    check(tag, o_dbg_data, exp);
  endtask

  initial begin
    // Initial reset so latches start from a known state.
    i_reset = 1'b0;
    nop();
    nop();
    i_reset = 1'b1;

    // Preload words 16 and 17, then put a store to 17 in flight and reset.
    issue(32'h40, 32'h12345678, 5'd0, M_SW, W_NONE, 1'b1);
    issue(32'h44, 32'hAAAAAAAA, 5'd0, M_SW, W_NONE, 1'b1);
    issue(32'h44, 32'h55555555, 5'd0, M_SW, W_NONE, 1'b1);
    i_reset = 1'b0;
    issue(32'h40, 32'h0, 5'd5, M_LW, W_LOAD, 1'b1);
    issue(32'h40, 32'h0, 5'd5, M_LW, W_LOAD, 1'b1);
    check("rst_exmem_alu", o_exmem_aluresult, 32'h0);
    check("rst_exmem_rd", {27'b0, o_exmem_rd}, 32'h0);
    check("rst_exmem_rw", {31'b0, o_exmem_regwrite}, 32'h0);
    check("rst_wb_data", o_wb_data, 32'h0);
    check("rst_wb_rd", {27'b0, o_wb_rd}, 32'h0);
    check("rst_wb_rw", {31'b0, o_wb_regwrite}, 32'h0);
    check("rst_wb_valid", {31'b0, o_wb_valid}, 32'h0);
    check("rst_misalign", {31'b0, o_misalign}, 32'h0);
    check_dbg("rst_mem_kept", 6'd16, 32'h12345678);
    check_dbg("rst_store_dropped", 6'd17, 32'hAAAAAAAA);
    i_reset = 1'b1;

    // Word store then dependent load.
    issue(32'h10, 32'hDEADBEEF, 5'd0, M_SW, W_NONE, 1'b1);
    check("sw_fwd_alu", o_exmem_aluresult, 32'h10);
    check("sw_exmem_rw", {31'b0, o_exmem_regwrite}, 32'h0);
    issue(32'h10, 32'h0, 5'd8, M_LW, W_LOAD, 1'b1);
    check("lw_exmem_rd", {27'b0, o_exmem_rd}, 32'd8);
    check("lw_exmem_rw", {31'b0, o_exmem_regwrite}, 32'h1);
    check_dbg("sw_dbg4", 6'd4, 32'hDEADBEEF);
    nop();
    check("lw_wb_data", o_wb_data, 32'hDEADBEEF);
    check("lw_wb_rd", {27'b0, o_wb_rd}, 32'd8);
    check("lw_wb_rw", {31'b0, o_wb_regwrite}, 32'h1);
    check("lw_wb_valid", {31'b0, o_wb_valid}, 32'h1);

    // Sub-word loads and byte store on word 8.
    issue(32'h20, 32'h80F07F81, 5'd0, M_SW, W_NONE, 1'b1);
    issue(32'h20, 32'h0, 5'd1, M_LB, W_LOAD, 1'b1);
    issue(32'h23, 32'h0, 5'd2, M_LBU, W_LOAD, 1'b1);
    check("lb_0x20", o_wb_data, 32'hFFFFFF81);
    issue(32'h22, 32'h0, 5'd3, M_LH, W_LOAD, 1'b1);
    check("lbu_0x23", o_wb_data, 32'h00000080);
    issue(32'h20, 32'h0, 5'd4, M_LHU, W_LOAD, 1'b1);
    check("lh_0x22", o_wb_data, 32'hFFFF80F0);
    issue(32'h21, 32'h00000055, 5'd0, M_SB, W_NONE, 1'b1);
    check("lhu_0x20", o_wb_data, 32'h00007F81);
    issue(32'h00001234, 32'h0, 5'd9, M_NONE, W_ALU, 1'b1);
    check("sb_wb_rw", {31'b0, o_wb_regwrite}, 32'h0);
    check_dbg("sb_word8", 6'd8, 32'h80F05581);
    nop();
    check("alu_wb_data", o_wb_data, 32'h00001234);
    check("alu_wb_rw", {31'b0, o_wb_regwrite}, 32'h1);

    // Halt with flush: store held, no write, latches frozen.
    issue(32'h30, 32'h11111111, 5'd0, M_SW, W_NONE, 1'b1);
    issue(32'h30, 32'hCAFEF00D, 5'd0, M_SW, W_NONE, 1'b1);
    i_halt  = 1'b1;
    i_flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(32'h7C, 32'h0, 5'd7, M_LW, W_LOAD, 1'b1);
      check_dbg("halt_no_write", 6'd12, 32'h11111111);
      check("halt_exmem_alu", o_exmem_aluresult, 32'h30);
      check("halt_wb_valid", {31'b0, o_wb_valid}, 32'h1);
    end
    i_halt  = 1'b0;
    i_flush = 1'b0;
    nop();
    check_dbg("halt_release_commit", 6'd12, 32'hCAFEF00D);

    // Flush alone: store becomes a bubble.
    i_flush = 1'b1;
    issue(32'h30, 32'h0BADF00D, 5'd0, M_SW, W_NONE, 1'b1);
    i_flush = 1'b0;
    check("flush_exmem_rw", {31'b0, o_exmem_regwrite}, 32'h0);
    nop();
    check("flush_wb_valid", {31'b0, o_wb_valid}, 32'h0);
    check_dbg("flush_no_write", 6'd12, 32'hCAFEF00D);

    // Address wrap: 4*64+8 maps to word 2.
    issue(32'h108, 32'h0000BEEF, 5'd0, M_SW, W_NONE, 1'b1);
    check("wrap_fwd_alu", o_exmem_aluresult, 32'h108);
    nop();
    check_dbg("wrap_word2", 6'd2, 32'h0000BEEF);

    // Misaligned word store is aligned down when the trap is not built in.
    issue(32'h22, 32'h77777777, 5'd0, M_SW, W_NONE, 1'b1);
    nop();
    check("misalign_flag_off", {31'b0, o_misalign}, 32'h0);
    check_dbg("misalign_aligned_down", 6'd8, 32'h77777777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
